// File: rtl/dft_pkg.sv
// Shared constants for the DFT datapath chain.
// Default word/address widths and a helper for FIFO capacity.
package dft_pkg;

    localparam int DFT_DATA_W = 12;
    localparam int DFT_ADDR_W = 8;

    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/dft_sample_fifo_if.sv
// Write/read handshake and status bundle of the DFT sample FIFO.
// master = producer/consumer side, slave = the FIFO itself.
interface dft_sample_fifo_if
    import dft_pkg::*;
#(
    parameter int DATA_W = DFT_DATA_W,
    parameter int ADDR_W = DFT_ADDR_W
);

    logic [DATA_W-1:0] wdata;
    logic              wr;
    logic              full;
    logic              afull;
    logic              overflow;
    logic [DATA_W-1:0] rdata;
    logic              rd;
    logic              rvalid;
    logic              empty;
    logic              aempty;
    logic              underflow;
    logic [ADDR_W:0]   level;
    logic              clr_err;

    modport master (
        output wdata, wr, rd, clr_err,
        input  full, afull, overflow, rdata, rvalid, empty, aempty, underflow, level
    );

    modport slave (
        input  wdata, wr, rd, clr_err,
        output full, afull, overflow, rdata, rvalid, empty, aempty, underflow, level
    );

endinterface

// File: rtl/dft_fifo_ram.sv
// Simple dual-port RAM, one write and one registered read port, no reset,
// written so that it infers block RAM (EBR on iCE40UP).
module dft_fifo_ram #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/dft_sample_fifo.sv
// Synchronous FIFO for ADC samples / spectral words with optional FWFT,
// programmable almost flags, occupancy count and sticky error flags.
module dft_sample_fifo
    import dft_pkg::*;
#(
    parameter int ADDR_W    = DFT_ADDR_W,
    parameter int DATA_W    = DFT_DATA_W,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = (2**ADDR_W) - 4,
    parameter int AEMPTY_TH = 4
) (
    input  logic               clk,
    input  logic               rst,
    dft_sample_fifo_if.slave   bus
);

    localparam int DEPTH = fifo_depth(ADDR_W);
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_L  = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AEMPTY_L = (ADDR_W+1)'(AEMPTY_TH);

    if (AFULL_TH <= 0 || AFULL_TH > DEPTH || AEMPTY_TH < 0 || AEMPTY_TH >= DEPTH) begin : g_bad_param
        $error("dft_sample_fifo: illegal AFULL_TH/AEMPTY_TH for DEPTH");
    end

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   level;
    logic              overflow_q;
    logic              underflow_q;
    logic              full_i;
    logic              empty_i;
    logic              wr_ok;
    logic              rd_ok;
    logic              ram_re;
    logic [DATA_W-1:0] ram_q_p1;

    assign full_i = (level == DEPTH_L);
    assign wr_ok  = bus.wr && !full_i;
    assign rd_ok  = bus.rd && !empty_i;

    dft_fifo_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (bus.wdata),
        .re    (ram_re),
        .raddr (rd_ptr),
        .rdata (ram_q_p1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + ADDR_W'(1);
            if (ram_re)
                rd_ptr <= rd_ptr + ADDR_W'(1);
            if (wr_ok && !rd_ok)
                level <= level + (ADDR_W+1)'(1);
            else if (!wr_ok && rd_ok)
                level <= level - (ADDR_W+1)'(1);
            // Setting an error wins over clearing it in the same cycle.
            if (bus.wr && full_i)
                overflow_q <= 1'b1;
            else if (bus.clr_err)
                overflow_q <= 1'b0;
            if (bus.rd && empty_i)
                underflow_q <= 1'b1;
            else if (bus.clr_err)
                underflow_q <= 1'b0;
        end
    end

    if (FWFT == 0) begin : g_std
        logic rvalid_q;
        logic rd_seen;

        assign empty_i = (level == '0);
        assign ram_re  = rd_ok;

        // The RAM output register has no reset; rdata reads as zero until the first pop.
        always_ff @(posedge clk) begin
            if (rst) begin
                rvalid_q <= 1'b0;
                rd_seen  <= 1'b0;
            end else begin
                rvalid_q <= rd_ok;
                if (rd_ok)
                    rd_seen <= 1'b1;
            end
        end

        assign bus.rdata  = rd_seen ? ram_q_p1 : '0;
        assign bus.rvalid = rvalid_q;
    end else begin : g_fwft
        logic [ADDR_W:0]   ram_cnt;
        logic              vld_p1;
        logic              vld_p2;
        logic [DATA_W-1:0] data_p2;
        logic              pf_load;

        // ---- stage p1: RAM read register; stage p2: head-of-queue prefetch ----
        assign empty_i = !vld_p2;
        assign pf_load = vld_p1 && (!vld_p2 || rd_ok);
        assign ram_re  = (ram_cnt != '0) && (!vld_p1 || pf_load);

        always_ff @(posedge clk) begin
            if (rst) begin
                ram_cnt <= '0;
                vld_p1  <= 1'b0;
                vld_p2  <= 1'b0;
                data_p2 <= '0;
            end else begin
                if (wr_ok && !ram_re)
                    ram_cnt <= ram_cnt + (ADDR_W+1)'(1);
                else if (!wr_ok && ram_re)
                    ram_cnt <= ram_cnt - (ADDR_W+1)'(1);
                if (ram_re)
                    vld_p1 <= 1'b1;
                else if (pf_load)
                    vld_p1 <= 1'b0;
                if (pf_load) begin
                    vld_p2  <= 1'b1;
                    data_p2 <= ram_q_p1;
                end else if (rd_ok) begin
                    vld_p2  <= 1'b0;
                end
            end
        end

        assign bus.rdata  = data_p2;
        assign bus.rvalid = vld_p2;
    end

    assign bus.full      = full_i;
    assign bus.afull     = (level >= AFULL_L);
    assign bus.aempty    = (level <= AEMPTY_L);
    assign bus.empty     = empty_i;
    assign bus.level     = level;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_dft_sample_fifo.sv
// Directed + random scoreboard bench for dft_sample_fifo, standard and FWFT builds
// at ADDR_W=4 side by side.
module tb_dft_sample_fifo;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [11:0] sq[$];
    logic [11:0] exp_d;

    dft_sample_fifo_if #(.DATA_W(12), .ADDR_W(4)) if0 ();
    dft_sample_fifo_if #(.DATA_W(12), .ADDR_W(4)) if1 ();

    dft_sample_fifo #(.ADDR_W(4), .DATA_W(12), .FWFT(0), .AFULL_TH(12), .AEMPTY_TH(4)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    dft_sample_fifo #(.ADDR_W(4), .DATA_W(12), .FWFT(1), .AFULL_TH(12), .AEMPTY_TH(4)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if0.wr = 1'b0; if0.rd = 1'b0; if0.clr_err = 1'b0; if0.wdata = '0;
        if1.wr = 1'b0; if1.rd = 1'b0; if1.clr_err = 1'b0; if1.wdata = '0;
    endtask

    task automatic chk_reset0(input string tag);
        chk({tag, "_level"},  32'(if0.level), 32'd0);
        chk({tag, "_empty"},  32'(if0.empty), 32'd1);
        chk({tag, "_full"},   32'(if0.full), 32'd0);
        chk({tag, "_afull"},  32'(if0.afull), 32'd0);
        chk({tag, "_aempty"}, 32'(if0.aempty), 32'd1);
        chk({tag, "_rvalid"}, 32'(if0.rvalid), 32'd0);
        chk({tag, "_rdata"},  32'(if0.rdata), 32'd0);
        chk({tag, "_ovf"},    32'(if0.overflow), 32'd0);
        chk({tag, "_unf"},    32'(if0.underflow), 32'd0);
    endtask

    initial begin
        int          mlvl;
        logic        mov;
        logic        mun;
        logic        w;
        logic        r;
        logic        wok;
        logic        rok;
        logic [11:0] d;

        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        chk_reset0("rst0");
        chk("rst1_empty",  32'(if1.empty), 32'd1);
        chk("rst1_rvalid", 32'(if1.rvalid), 32'd0);
        chk("rst1_rdata",  32'(if1.rdata), 32'd0);
        chk("rst1_level",  32'(if1.level), 32'd0);

        // Fill to capacity
        for (int i = 1; i <= 16; i++) begin
            if0.wr = 1'b1;
            if0.wdata = 12'(i);
            sq.push_back(12'(i));
            tick();
            chk("fill_level",  32'(if0.level), 32'(i));
            chk("fill_full",   32'(if0.full), 32'(i == 16));
            chk("fill_afull",  32'(if0.afull), 32'(i >= 12));
            chk("fill_aempty", 32'(if0.aempty), 32'(i <= 4));
        end
        if0.wdata = 12'h011;
        tick();
        if0.wr = 1'b0;
        chk("ovf_set",   32'(if0.overflow), 32'd1);
        chk("ovf_level", 32'(if0.level), 32'd16);
        chk("ovf_full",  32'(if0.full), 32'd1);

        // Drain in order
        if0.rd = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            exp_d = sq.pop_front();
            chk("drain_rvalid", 32'(if0.rvalid), 32'd1);
            chk("drain_rdata",  32'(if0.rdata), 32'(exp_d));
            chk("drain_level",  32'(if0.level), 32'(16 - i));
        end
        if0.rd = 1'b0;
        chk("drain_empty", 32'(if0.empty), 32'd1);
        if0.rd = 1'b1;
        tick();
        if0.rd = 1'b0;
        chk("unf_set",    32'(if0.underflow), 32'd1);
        chk("unf_rdata",  32'(if0.rdata), 32'h010);
        chk("unf_rvalid", 32'(if0.rvalid), 32'd0);

        // Set beats clear in the same cycle, then clear alone
        if0.clr_err = 1'b1;
        if0.rd = 1'b1;
        tick();
        if0.rd = 1'b0;
        chk("clr_prio_unf", 32'(if0.underflow), 32'd1);
        chk("clr_prio_ovf", 32'(if0.overflow), 32'd0);
        tick();
        if0.clr_err = 1'b0;
        chk("clr_unf", 32'(if0.underflow), 32'd0);

        // Simultaneous wr+rd while full
        for (int i = 1; i <= 16; i++) begin
            if0.wr = 1'b1;
            if0.wdata = 12'(12'h100 + i);
            sq.push_back(12'(12'h100 + i));
            tick();
        end
        if0.rd = 1'b1;
        if0.wdata = 12'h1FF;
        tick();
        if0.wr = 1'b0;
        exp_d = sq.pop_front();
        chk("wrrd_full_rdata", 32'(if0.rdata), 32'(exp_d));
        chk("wrrd_full_level", 32'(if0.level), 32'd15);
        chk("wrrd_full_ovf",   32'(if0.overflow), 32'd1);
        for (int i = 1; i <= 15; i++) begin
            tick();
            exp_d = sq.pop_front();
            chk("wrrd_drain_rdata", 32'(if0.rdata), 32'(exp_d));
        end
        chk("wrrd_drain_empty", 32'(if0.empty), 32'd1);

        // Simultaneous wr+rd while empty
        if0.wr = 1'b1;
        if0.wdata = 12'h2AA;
        tick();
        if0.wr = 1'b0;
        if0.rd = 1'b0;
        sq.push_back(12'h2AA);
        chk("wrrd_empty_level",  32'(if0.level), 32'd1);
        chk("wrrd_empty_unf",    32'(if0.underflow), 32'd1);
        chk("wrrd_empty_rvalid", 32'(if0.rvalid), 32'd0);
        if0.rd = 1'b1;
        tick();
        if0.rd = 1'b0;
        exp_d = sq.pop_front();
        chk("wrrd_empty_rdata", 32'(if0.rdata), 32'(exp_d));
        if0.clr_err = 1'b1;
        tick();
        if0.clr_err = 1'b0;

        // Random streaming against the scoreboard
        mlvl = 0;
        mov  = 1'b0;
        mun  = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (((c / 100) % 2) == 0) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            d = 12'($urandom);
            if0.wr = w;
            if0.rd = r;
            if0.wdata = d;
            wok = w && (mlvl < 16);
            rok = r && (mlvl > 0);
            if (w && mlvl == 16) mov = 1'b1;
            if (r && mlvl == 0)  mun = 1'b1;
            tick();
            if (rok) begin
                exp_d = sq.pop_front();
                chk("s_rdata", 32'(if0.rdata), 32'(exp_d));
            end
            if (wok) sq.push_back(d);
            mlvl = mlvl + int'(wok) - int'(rok);
            chk("s_rvalid", 32'(if0.rvalid), 32'(rok));
            chk("s_level",  32'(if0.level), 32'(mlvl));
            chk("s_full",   32'(if0.full), 32'(mlvl == 16));
            chk("s_empty",  32'(if0.empty), 32'(mlvl == 0));
            chk("s_ovf",    32'(if0.overflow), 32'(mov));
            chk("s_unf",    32'(if0.underflow), 32'(mun));
        end
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sq.delete();

        // Reset in the middle of traffic
        for (int i = 0; i < 9; i++) begin
            if0.wr = 1'b1;
            if0.wdata = 12'(12'h400 + i);
            tick();
        end
        chk("mid_pre_level", 32'(if0.level), 32'd9);
        if0.rd = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if0.wr = 1'b0;
        if0.rd = 1'b0;
        chk_reset0("midrst");
        if0.wr = 1'b1;
        if0.wdata = 12'h5A5;
        sq.push_back(12'h5A5);
        tick();
        if0.wr = 1'b0;
        if0.rd = 1'b1;
        tick();
        if0.rd = 1'b0;
        exp_d = sq.pop_front();
        chk("midrst_rvalid", 32'(if0.rvalid), 32'd1);
        chk("midrst_rdata",  32'(if0.rdata), 32'(exp_d));
        chk("midrst_empty",  32'(if0.empty), 32'd1);

        // FWFT latency
        if1.wr = 1'b1;
        if1.wdata = 12'hABC;
        sq.push_back(12'hABC);
        tick();
        if1.wr = 1'b0;
        chk("fwft_n_empty", 32'(if1.empty), 32'd1);
        chk("fwft_n_level", 32'(if1.level), 32'd1);
        tick();
        chk("fwft_n1_empty", 32'(if1.empty), 32'd1);
        tick();
        exp_d = sq.pop_front();
        chk("fwft_n2_empty",  32'(if1.empty), 32'd0);
        chk("fwft_n2_rdata",  32'(if1.rdata), 32'(exp_d));
        chk("fwft_n2_rvalid", 32'(if1.rvalid), 32'd1);
        if1.rd = 1'b1;
        tick();
        if1.rd = 1'b0;
        chk("fwft_pop_empty", 32'(if1.empty), 32'd1);
        chk("fwft_pop_level", 32'(if1.level), 32'd0);
        if1.rd = 1'b1;
        tick();
        if1.rd = 1'b0;
        chk("fwft_unf", 32'(if1.underflow), 32'd1);

        // FWFT back-to-back pops
        for (int k = 0; k < 6; k++) begin
            if1.wr = 1'b1;
            if1.wdata = 12'(12'h300 + k);
            sq.push_back(12'(12'h300 + k));
            tick();
        end
        if1.wr = 1'b0;
        tick();
        tick();
        chk("fwft_b2b_level", 32'(if1.level), 32'd6);
        for (int k = 0; k < 6; k++) begin
            exp_d = sq.pop_front();
            chk("fwft_b2b_rdata", 32'(if1.rdata), 32'(exp_d));
            chk("fwft_b2b_empty", 32'(if1.empty), 32'd0);
            if1.rd = 1'b1;
            tick();
        end
        if1.rd = 1'b0;
        chk("fwft_b2b_end_empty", 32'(if1.empty), 32'd1);
        chk("fwft_b2b_end_level", 32'(if1.level), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dft_sample_fifo.md
# dft_sample_fifo

Parametrised, vendor-independent synchronous FIFO for the DFT datapath. It buffers ADC samples and intermediate spectral words between the acquisition front end and the FFT engine. Compared with the previous generation it adds first-word-fall-through (FWFT) mode, programmable almost-full/almost-empty thresholds, an occupancy count and sticky overflow/underflow flags. Storage is an inferred simple dual-port RAM, so it maps to EBR on iCE40UP and is portable elsewhere.

## Interface
- ADDR_W, 8: log2 of capacity; capacity DEPTH = 2**ADDR_W words exactly.
- DATA_W, 12: data width.
- FWFT, 0: 0 = standard read (data one cycle after rd); 1 = head word presented on rdata while !empty.
- AFULL_TH, 2**ADDR_W-4: afull asserted when level >= AFULL_TH.
- AEMPTY_TH, 4: aempty asserted when level <= AEMPTY_TH.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wdata  in  DATA_W  write data.
- wr  in  1  write request.
- full  out  1  level == DEPTH.
- afull  out  1  level >= AFULL_TH.
- overflow  out  1  sticky: wr while full.
- rdata  out  DATA_W  read data.
- rd  in  1  read request / pop.
- rvalid  out  1  rdata valid (FWFT=0: one-cycle pulse; FWFT=1: equals !empty).
- empty  out  1  no word available to read.
- aempty  out  1  level <= AEMPTY_TH.
- underflow  out  1  sticky: rd while empty.
- level  out  ADDR_W+1  words held, including any word in the FWFT output register.
- clr_err  in  1  clears overflow/underflow.

## Operation
- Write accepted iff wr && !full; read accepted iff rd && !empty. Both use pre-edge flag values, so outcomes are independent of each other.
- Rejected write: data dropped, pointers unchanged, overflow set. Rejected read: rdata/pointers unchanged, underflow set.
- wr && rd while full: read accepted, write rejected, overflow set, level DEPTH-1. wr && rd while empty: write accepted, read rejected, underflow set.
- wr && rd both accepted: level unchanged.
- Pointers are ADDR_W bits and wrap from DEPTH-1 to 0. level is a registered up/down counter and never exceeds DEPTH.
- FWFT=0: an accepted read registers mem[rd_ptr] into rdata and pulses rvalid. rdata otherwise holds its last value. empty = (level == 0).
- FWFT=1: a prefetch register holds the head word. It loads from RAM when it is empty or being popped and the RAM holds unread data. empty = !prefetch_valid.
- Sticky flags: set has priority over clr_err in the same cycle.
- All outputs are driven from registers or from comparisons on registered state only. There is no combinational path from wr/rd/wdata to any output.
- Reset (at any time, including mid-burst): pointers 0, level 0, full 0, afull 0 (for AFULL_TH>0), empty 1, aempty 1, rvalid 0, rdata 0, overflow 0, underflow 0. Buffered contents are discarded. RAM array is not cleared.

## Timing
- Write at edge N: level and full/afull/aempty update after edge N.
- FWFT=0 read at edge N: rdata/rvalid valid after edge N. Word written at edge N is readable by rd sampled at edge N+1.
- FWFT=1: word written into an empty FIFO at edge N appears on rdata with empty=0 after edge N+2. Back-to-back pops sustain one word per cycle.
- Throughput: one write and one read per cycle, indefinitely.
- Parameter legality (elaboration-time check): 0 < AFULL_TH <= DEPTH and 0 <= AEMPTY_TH < DEPTH.

## Structure
- Shared package dft_pkg: default DATA_W/ADDR_W constants for the DFT chain and a localparam function for DEPTH.
- Sub-module dft_fifo_ram: simple dual-port RAM (registered read, 1W/1R, no reset) inferred as EBR.
- Top level holds the pointers, level counter, flags, the FWFT prefetch register and the error logic.

## Test plan
- Reset and fill (ADDR_W=4, FWFT=0): 16 writes 0x001..0x010 -> full=1 after the 16th, level=16, afull from level 12. A 17th write sets overflow and leaves level=16.
- Drain order: 16 reads -> rdata 0x001..0x010 in order with rvalid each cycle. empty=1 after the last read. An extra rd sets underflow and rdata stays 0x010.
- Simultaneous ops: at level 16, wr=rd=1 -> level 15, overflow set. At level 0, wr=rd=1 -> level 1, underflow set.
- FWFT=1 latency: single write 0xABC at edge N -> rdata=0xABC, empty=0 after edge N+2. rd pops it and empty=1.
- Wrap-around streaming: 1000 cycles of random wr/rd at ADDR_W=4 against a scoreboard -> exact data order, level matches model, no spurious flags.
- Mid-operation reset: rst at level 9 with wr=rd=1 -> all outputs at reset values next cycle. A following write/read returns the new data only.
